// File: rtl/seg7_capture.sv
// seg7_capture: synchronise a raw 7-segment pattern, wait for it to settle, decode it back to a hex digit.
module seg7_capture #(
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    output logic [3:0] digit,
    output logic       blank,
    output logic       err,
    output logic       valid,
    output logic [7:0] upd_count
);
    localparam logic [6:0]  OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [15:0] LAST = 16'(STABLE_CYCLES - 1);
    typedef enum logic {LOCKED, SETTLE} state_t;
    state_t      state_q, state_d;
    logic [6:0]  s1_q, s2_q, prev_q, prev_d, last_q, last_d, norm;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  digit_q, digit_d, hex;
    logic        blank_q, blank_d, err_q, err_d, valid_q, valid_d;
    logic [7:0]  upd_q, upd_d;
    logic        changed, fire, hit;
    // prev/last hold raw (un-normalised) patterns, so reset loads the raw all-off value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= OFF;
            s2_q    <= OFF;
            prev_q  <= OFF;
            last_q  <= OFF;
            cnt_q   <= '0;
            state_q <= LOCKED;
            digit_q <= '0;
            blank_q <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            upd_q   <= '0;
        end else begin
            s1_q    <= seg_in;
            s2_q    <= s1_q;
            prev_q  <= prev_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            digit_q <= digit_d;
            blank_q <= blank_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            upd_q   <= upd_d;
        end
    end
    assign changed = s2_q != prev_q;
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        cnt_d   = cnt_q;
        if (changed) begin
            prev_d  = s2_q;
            cnt_d   = '0;
            state_d = SETTLE;
        end else if (state_q == SETTLE) begin
            state_d = cnt_q == LAST ? LOCKED : SETTLE;
            cnt_d   = cnt_q == LAST ? cnt_q : cnt_q + 16'd1;
        end
    end
    assign norm = ACTIVE_LOW ? ~prev_q : prev_q;
    always_comb begin
        hit = 1'b1;
        hex = 4'h0;
        case (norm)
            7'b1111110: hex = 4'h0;
            7'b0110000: hex = 4'h1;
            7'b1101101: hex = 4'h2;
            7'b1111001: hex = 4'h3;
            7'b0110011: hex = 4'h4;
            7'b1011011: hex = 4'h5;
            7'b1011111: hex = 4'h6;
            7'b1110000: hex = 4'h7;
            7'b1111111: hex = 4'h8;
            7'b1111011: hex = 4'h9;
            7'b1110111: hex = 4'hA;
            7'b0011111: hex = 4'hB;
            7'b1001110: hex = 4'hC;
            7'b0111101: hex = 4'hD;
            7'b1001111: hex = 4'hE;
            7'b1000111: hex = 4'hF;
            default:    hit = 1'b0;
        endcase
    end
    // a settle that ends on the already-locked pattern was a glitch: no update
    always_comb begin
        fire    = state_q == SETTLE && !changed && cnt_q == LAST && prev_q != last_q;
        last_d  = fire ? prev_q : last_q;
        digit_d = fire && hit ? hex : digit_q;
        blank_d = fire ? norm == 7'h00 : blank_q;
        err_d   = fire ? !hit && norm != 7'h00 : err_q;
        valid_d = fire;
        upd_d   = upd_q + 8'(fire);
    end
    assign digit     = digit_q;
    assign blank     = blank_q;
    assign err       = err_q;
    assign valid     = valid_q;
    assign upd_count = upd_q;
endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: scoreboard bench for two seg7_capture instances (active-low/4 cycles, active-high/1 cycle).
module tb_seg7_capture;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_a = 7'h7F, seg_b = 7'h00;
    logic [3:0] a_digit, b_digit;
    logic       a_blank, a_err, a_valid, b_blank, b_err, b_valid;
    logic [7:0] a_upd, b_upd;

    seg7_capture #(.ACTIVE_LOW(1'b1), .STABLE_CYCLES(4)) u_a (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_a), .digit(a_digit), .blank(a_blank),
        .err(a_err), .valid(a_valid), .upd_count(a_upd));
    seg7_capture #(.ACTIVE_LOW(1'b0), .STABLE_CYCLES(1)) u_b (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_b), .digit(b_digit), .blank(b_blank),
        .err(b_err), .valid(b_valid), .upd_count(b_upd));

    always #5 clk = ~clk;

    typedef struct { logic [13:0] v; int at; } exp_t;
    exp_t qa[$];
    exp_t qb[$];
    int checks = 0, failures = 0, cyc = 0;
    logic [6:0] glyph [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                               7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    logic [3:0] md [2];
    logic       mb [2];
    logic       me [2];
    logic [7:0] mc [2];
    logic [6:0] ml [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int lookup(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (glyph[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            md[w] = 4'h0; mb[w] = 1'b0; me[w] = 1'b0; mc[w] = 8'h00; ml[w] = 7'h00;
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (a_valid) begin
            chk("a_strobe_expected", 32'(qa.size() != 0), 1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("a_latency", cyc, e.at);
                chk("a_outputs", {a_digit, a_blank, a_err, a_upd}, e.v);
            end
        end
        if (b_valid) begin
            chk("b_strobe_expected", 32'(qb.size() != 0), 1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("b_latency", cyc, e.at);
                chk("b_outputs", {b_digit, b_blank, b_err, b_upd}, e.v);
            end
        end
    endtask

    // p is the normalised (1 = lit) pattern
    task automatic apply(input int w, input logic [6:0] p, input int hold);
        int s;
        int k;
        bit pushed;
        exp_t e;
        s = (w == 0) ? 4 : 1;
        pushed = 1'b0;
        if (w == 0) seg_a = ~p; else seg_b = p;
        if (hold >= 3 + s && p != ml[w]) begin
            k = lookup(p);
            ml[w] = p;
            if (p == 7'h00) begin mb[w] = 1'b1; me[w] = 1'b0; end
            else if (k < 0) begin mb[w] = 1'b0; me[w] = 1'b1; end
            else begin md[w] = 4'(k); mb[w] = 1'b0; me[w] = 1'b0; end
            mc[w]++;
            e.v = {md[w], mb[w], me[w], mc[w]};
            e.at = cyc + 3 + s;
            if (w == 0) qa.push_back(e); else qb.push_back(e);
            pushed = 1'b1;
        end
        repeat (hold) tick();
        if (pushed) chk(w == 0 ? "a_drained" : "b_drained", w == 0 ? qa.size() : qb.size(), 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_a_digit"}, a_digit, 0);
        chk({tag, "_a_flags"}, {a_blank, a_err, a_valid}, 0);
        chk({tag, "_a_upd"}, a_upd, 0);
        chk({tag, "_b_digit"}, b_digit, 0);
        chk({tag, "_b_flags"}, {b_blank, b_err, b_valid}, 0);
        chk({tag, "_b_upd"}, b_upd, 0);
    endtask

    initial begin
        model_reset();
        repeat (3) tick();
        chk_reset("reset");
        rst_n = 1'b1;
        repeat (5) tick();
        chk_reset("post_release");
        apply(0, glyph[2], 10);
        chk("basic_digit", a_digit, 2);
        chk("basic_upd", a_upd, 1);
        for (int i = 0; i < 16; i++) apply(0, glyph[i], 10);
        chk("sweep_digit", a_digit, 4'hF);
        chk("sweep_upd", a_upd, 17);
        apply(0, glyph[3], 10);
        apply(0, glyph[8], 2);
        apply(0, glyph[3], 10);
        chk("glitch_digit", a_digit, 3);
        chk("glitch_upd", a_upd, 18);
        apply(0, glyph[8], 2);
        apply(0, glyph[5], 10);
        chk("glitch_then_5", a_digit, 5);
        apply(0, glyph[7], 10);
        apply(0, 7'h00, 10);
        chk("blank_flags", {a_digit, a_blank, a_err}, {4'h7, 1'b1, 1'b0});
        apply(0, 7'b1000001, 10);
        chk("err_flags", {a_digit, a_blank, a_err}, {4'h7, 1'b0, 1'b1});
        apply(0, glyph[1], 10);
        chk("err_clear", {a_digit, a_blank, a_err}, {4'h1, 1'b0, 1'b0});
        apply(1, glyph[1], 5);
        chk("polarity_digit", b_digit, 1);
        for (int i = 0; i < 255; i++) apply(1, (i % 2 == 1) ? glyph[1] : glyph[0], 5);
        chk("wrap_upd", b_upd, 0);
        apply(1, 7'h00, 5);
        seg_a = ~glyph[4];
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk_reset("mid_settle");
        model_reset();
        repeat (3) tick();
        chk_reset("held_reset");
        rst_n = 1'b1;
        apply(0, glyph[4], 10);
        chk("after_reset_digit", a_digit, 4);
        chk("after_reset_upd", a_upd, 1);
        chk("b_quiet_after_reset", b_upd, 0);
        chk("final_qa_empty", qa.size(), 0);
        chk("final_qb_empty", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
